jk_mod_counter: RTL and testbench
=================================

// Module: jk_mod_counter
// PURPOSE
//  Synchronous modulo-N up/down counter whose state bits are JK cells; per-bit J/K
//  inputs come from excitation logic, so this stage drives JK bits directly.
//  Used as the timing/sequencing stage downstream of the JK flip-flop library.
//  Provides load, enable, direction, terminal-count and wrap indication.
// PARAMETERS
//  WIDTH    4   counter width in bits (2..16)
//  MODULUS  10  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk      in   1      rising-edge clock, single clock domain
//  rst      in   1      asynchronous, active-low reset
//  en       in   1      count enable
//  up       in   1      direction: 1 = increment, 0 = decrement
//  ld       in   1      synchronous load strobe
//  ld_val   in   WIDTH  load value
//  q        out  WIDTH  current count (JK cell outputs)
//  qn       out  WIDTH  bitwise ~q
//  tc       out  1      terminal count, combinational
//  wrap     out  1      registered one-cycle pulse after a wrap/saturate event
//  ld_err   out  1      registered one-cycle pulse after an out-of-range load
// BEHAVIOUR
//  - Reset (rst=0, async): q=0, qn=all-ones, wrap=0, ld_err=0. Release is sync to clk.
//  - Priority each rising edge: ld > en > hold.
//  - ld=1: q <= ld_val if ld_val < MODULUS; else q <= MODULUS-1 and ld_err=1 next cycle.
//    Load ignores en/up; wrap=0 on load cycles.
//  - en=1, ld=0: up=1: q <= (q==MODULUS-1) ? 0 : q+1; up=0: q <= (q==0) ? MODULUS-1 : q-1.
//  - en=0, ld=0: q holds (every cell gets J=K=0).
//  - Excitation per bit i, next value n: q[i]=0 -> J=n[i], K=0; q[i]=1 -> J=0, K=~n[i].
//    Cell truth: 00 hold, 01 clear, 10 set, 11 toggle.
//  - tc = en & ~ld & ((up & q==MODULUS-1) | (~up & q==0)); no reset dependency beyond q.
//  - wrap asserts for exactly one cycle, the cycle after an edge where tc=1.
//  - Latency: q updates on the edge that samples en/ld; tc valid same cycle as inputs.
//  - Direction change mid-count takes effect on the next edge; no glitch in q.
//  - Reset asserted mid-count: q, wrap, ld_err clear immediately, no clk needed.
//  - Arithmetic in WIDTH+1 bits internally; q never leaves 0..MODULUS-1.
// CONFIGURATION
//  - Macro JK_CNT_SAT_EN:
//    defined: saturating; at MODULUS-1 counting up (or 0 counting down) q holds,
//    tc still asserts, wrap pulses each cycle saturation blocks a step.
//    undefined: modular wrap as above (default build).
// STRUCTURE
//  - Shared package jk_pkg: localparams JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10,
//    JK_TGL=2'b11; function jk_excite(cur, nxt) returning {J,K}.
//  - Sub-module jk_cell: one JK bit, async active-low reset to 0, outputs q/qn;
//    generate-loop WIDTH instances. Next-state, tc, wrap, ld_err logic in top level.
// TESTING
//  1 Reset: rst=0 mid-count at q=7 -> q=0, qn=4'hF, wrap=0 without a clk edge.
//  2 Up wrap: MODULUS=10, en=1, up=1 from 0 -> 1..9, tc=1 at 9, q=0 next, wrap=1 one cycle.
//  3 Down wrap: load 0, en=1, up=0 -> q=9 next edge, tc=1 at q=0, wrap pulse.
//  4 Load range: ld_val=5 -> q=5, ld_err=0; ld_val=12 -> q=9, ld_err=1 for one cycle.
//  5 Priority/hold: ld=1,en=1,ld_val=3 at q=8 -> q=3, wrap=0; en=0 for 4 edges -> q=3.
//  6 JK_CNT_SAT_EN build: up from 8 with en=1 -> 9,9,9; tc=1, wrap pulses each held edge.

Source files
------------

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK cell control encodings and excitation helper for jk_mod_counter
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // {J,K} that moves a cell from cur to nxt; a held bit always gets 00
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return cur ? {1'b0, ~nxt} : {nxt, 1'b0};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop bit, async active-low reset to 0
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qn = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from JK cells
// Macro JK_CNT_SAT_EN selects saturation at the ends instead of modular wrap.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             wrap,
  output logic             ld_err
);

  // One extra bit so MODULUS == 2**WIDTH is representable in the compares
  localparam logic [WIDTH:0] MOD_W   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_TOP = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   cur_w;
  logic             at_top;
  logic             at_zero;
  logic             ld_ok;
  logic [WIDTH-1:0] nxt;

  assign cur_w   = {1'b0, q};
  assign at_top  = (cur_w == MOD_TOP);
  assign at_zero = (cur_w == '0);
  assign ld_ok   = ({1'b0, ld_val} < MOD_W);
  assign tc      = en & ~ld & ((up & at_top) | (~up & at_zero));

  always_comb begin
    nxt = q;
    if (ld) begin
      nxt = ld_ok ? ld_val : WIDTH'(MOD_TOP);
    end else if (tc) begin
`ifdef JK_CNT_SAT_EN
      nxt = q;
`else
      nxt = up ? '0 : WIDTH'(MOD_TOP);
`endif
    end else if (en) begin
      nxt = up ? WIDTH'(cur_w + 1'b1) : WIDTH'(cur_w - 1'b1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] jk;
    assign jk = jk_excite(q[i], nxt[i]);
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk[1]),
      .k   (jk[0]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      wrap   <= tc;
      ld_err <= ld & ~ld_ok;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - randomized and directed bench for jk_mod_counter against a behavioural model
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
`ifdef JK_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             tc;
  logic             wrap;
  logic             ld_err;

  int total = 0;
  int bad   = 0;
  int m     = 0;
  int m_wrap  = 0;
  int m_lderr = 0;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .ld     (ld),
    .ld_val (ld_val),
    .q      (q),
    .qn     (qn),
    .tc     (tc),
    .wrap   (wrap),
    .ld_err (ld_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("q", int'(q), m);
    chk("qn", int'(qn), (~m) & ((1 << WIDTH) - 1));
    chk("wrap", int'(wrap), m_wrap);
    chk("ld_err", int'(ld_err), m_lderr);
  endtask

  // Apply inputs, check tc before the edge, then advance model and check state
  task automatic step(input logic l, input logic e, input logic u, input int v);
    bit term;
    ld = l; en = e; up = u; ld_val = WIDTH'(v);
    #1;
    term = e && !l && ((u && m == MODULUS - 1) || (!u && m == 0));
    chk("tc", int'(tc), int'(term));
    @(posedge clk);
    m_wrap  = 0;
    m_lderr = 0;
    if (l) begin
      if (v < MODULUS) m = v;
      else begin
        m = MODULUS - 1;
        m_lderr = 1;
      end
    end else if (e) begin
      m_wrap = int'(term);
      if (!(SAT && term)) m = u ? (m + 1) % MODULUS : (m + MODULUS - 1) % MODULUS;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; ld_val = '0;
    #2;
    check_outputs();
    chk("tc_rst", int'(tc), 0);
    #10 rst = 1'b1;

    // up count through the top
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 0);

    // asynchronous reset mid-count at 7
    step(1'b1, 1'b0, 1'b0, 7);
    #1 rst = 1'b0;
    #1;
    m = 0; m_wrap = 0; m_lderr = 0;
    check_outputs();
    #1 rst = 1'b1;

    // down from 0
    step(1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0);

    // load range
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b1, 1'b1, 1'b1, 12);
    step(1'b0, 1'b0, 1'b1, 0);

    // priority and hold
    step(1'b1, 1'b0, 1'b0, 8);
    step(1'b1, 1'b1, 1'b1, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 0);

    // from 8 upward: wraps, or saturates in the saturating build
    step(1'b1, 1'b0, 1'b0, 8);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << WIDTH) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
